// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator call scheduler: controller state
// encoding, travel direction constants and the "calls ahead" query.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVING    = 2'd1,
    DOOR_OPEN = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Widest configuration the helper below has to cover.
  localparam int MAX_FLOORS  = 16;
  localparam int MAX_FLOOR_W = 4;

  // True when any pending call lies strictly beyond floor in direction dir.
  // Callers zero-extend narrower masks, so unused floors never count.
  // Indices are compared as integers, so no floor arithmetic can wrap.
  function automatic logic calls_ahead(input logic [MAX_FLOORS-1:0]  pend,
                                       input logic [MAX_FLOOR_W-1:0] floor,
                                       input logic                   dir);
    logic found;
    found = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (pend[i]) begin
        if ((dir == DIR_UP) && (i > int'(floor))) found = 1'b1;
        if ((dir == DIR_DOWN) && (i < int'(floor))) found = 1'b1;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/elevator_call_scheduler_door_timer.sv
// Door dwell timer: a loadable down-counter. Both load (door opens) and
// reload (hall call at the open floor) restart it at DOOR_CYCLES-1. It
// then counts down to zero and holds there. zero tells the controller
// that the dwell has run out.
module door_timer #(
  parameter int DOOR_CYCLES = 8,
  parameter int TIMER_W     = $clog2(DOOR_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic reload,
  output logic zero
);

  localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(DOOR_CYCLES - 1);

  logic [TIMER_W-1:0] count;

  // Countdown register: restart on load/reload, otherwise decrement to zero.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      count <= '0;
    end else if (load || reload) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/elevator_call_scheduler.sv
// Central elevator scheduler. It latches debounced hall-call pulses into a
// pending mask. It follows the cabin floor by floor from sensor pulses.
// Travel direction follows SCAN: keep going while calls remain ahead,
// otherwise reverse. Motor, door and busy commands are all registered.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOORS      = 4,
  parameter int FLOOR_W     = 2,
  parameter int DOOR_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  call_pulse,
  input  logic               floor_pulse,
  output logic               motor_up,
  output logic               motor_down,
  output logic               door_open,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic [FLOORS-1:0]  pending,
  output logic               busy
);

  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

  state_t             state_q, state_d;
  logic               dir_q, dir_d;
  logic [FLOOR_W-1:0] floor_d;
  logic [FLOOR_W-1:0] step_floor;
  logic               step_ok;
  logic [FLOORS-1:0]  pending_d;
  logic [FLOORS-1:0]  served_mask;
  logic [FLOORS-1:0]  cur_mask;
  logic [FLOORS-1:0]  blocked_calls;
  logic               timer_load, timer_reload, timer_zero;
  logic               motor_up_d, motor_down_d, door_open_d, busy_d;

  assign cur_mask = FLOORS'(1) << cur_floor;

  door_timer #(
    .DOOR_CYCLES (DOOR_CYCLES)
  ) u_door_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .reload (timer_reload),
    .zero   (timer_zero)
  );

  // Candidate next floor in the travel direction; step_ok is low at the end stops.
  always_comb begin
    if (dir_q == DIR_UP) begin
      step_ok    = (cur_floor != TOP_FLOOR);
      step_floor = cur_floor + FLOOR_W'(1);
    end else begin
      step_ok    = (cur_floor != '0);
      step_floor = cur_floor - FLOOR_W'(1);
    end
  end

  // Next-state logic: SCAN direction choice, floor stepping, stop and dwell decisions.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d      = state_q;
    dir_d        = dir_q;
    floor_d      = cur_floor;
    served_mask  = '0;
    timer_load   = 1'b0;
    timer_reload = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending != '0) begin
          if (pending[cur_floor]) begin
            state_d     = DOOR_OPEN;
            served_mask = cur_mask;
            timer_load  = 1'b1;
          end else begin
            state_d = MOVING;
            if (!calls_ahead(MAX_FLOORS'(pending), MAX_FLOOR_W'(cur_floor), dir_q)) begin
              dir_d = ~dir_q;
            end
          end
        end
      end
      MOVING: begin
        // A pulse that would run past an end floor is ignored entirely.
        if (floor_pulse && step_ok) begin
          floor_d = step_floor;
          if (pending[step_floor]) begin
            state_d     = DOOR_OPEN;
            served_mask = FLOORS'(1) << step_floor;
            timer_load  = 1'b1;
          end else if (!calls_ahead(MAX_FLOORS'(pending), MAX_FLOOR_W'(step_floor), dir_q)) begin
            state_d = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
        // A call at the open floor keeps the door open instead of queueing a new stop.
        if (call_pulse[cur_floor]) begin
          timer_reload = 1'b1;
        end else if (timer_zero) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pending mask update: calls at the open door are absorbed, and a served floor's clear beats a same-cycle call.
  always_comb begin
    blocked_calls = (state_q == DOOR_OPEN) ? cur_mask : '0;
    pending_d     = (pending | (call_pulse & ~blocked_calls)) & ~served_mask;
  end

  // Output decode from the next state so motor, door and busy flops stay in step with the state register.
  always_comb begin
    motor_up_d   = (state_d == MOVING) && (dir_d == DIR_UP);
    motor_down_d = (state_d == MOVING) && (dir_d == DIR_DOWN);
    door_open_d  = (state_d == DOOR_OPEN);
    busy_d       = (state_d != IDLE);
  end

  // State and output registers; reset drops motors, door and all calls at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dir_q      <= DIR_UP;
      cur_floor  <= '0;
      pending    <= '0;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      door_open  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cur_floor  <= floor_d;
      pending    <= pending_d;
      motor_up   <= motor_up_d;
      motor_down <= motor_down_d;
      door_open  <= door_open_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench for elevator_call_scheduler. A behavioural model tracks
// the cabin as plain integers (mode, floor, remaining open cycles).
// Outputs are compared against it on every falling edge. Directed scenarios
// also pin the model with literal expectations. A randomized phase follows.
module tb_elevator_call_scheduler;

  localparam int FLOORS      = 4;
  localparam int FLOOR_W     = 2;
  localparam int DOOR_CYCLES = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [FLOORS-1:0]  call_pulse;
  logic               floor_pulse;
  logic               motor_up;
  logic               motor_down;
  logic               door_open;
  logic [FLOOR_W-1:0] cur_floor;
  logic [FLOORS-1:0]  pending;
  logic               busy;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;
  int stops[$];

  elevator_call_scheduler #(
    .FLOORS      (FLOORS),
    .FLOOR_W     (FLOOR_W),
    .DOOR_CYCLES (DOOR_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .call_pulse  (call_pulse),
    .floor_pulse (floor_pulse),
    .motor_up    (motor_up),
    .motor_down  (motor_down),
    .door_open   (door_open),
    .cur_floor   (cur_floor),
    .pending     (pending),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 travelling, 2 door open; left = open cycles still to go.
  typedef struct {
    int         mode;
    int         floor;
    bit         up;
    bit [3:0]   pend;
    int         left;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.mode  = 0;
    r.floor = 0;
    r.up    = 1'b1;
    r.pend  = '0;
    r.left  = 0;
    return r;
  endfunction

  function automatic bit any_ahead(bit [3:0] p, int f, bit up);
    for (int i = 0; i < FLOORS; i++) begin
      if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic model_t model_next(model_t cur, bit [3:0] c, bit fp);
    model_t n;
    int served;
    int nf;
    n = cur;
    served = -1;
    case (cur.mode)
      0: begin
        if (cur.pend != 0) begin
          if (cur.pend[cur.floor]) begin
            n.mode = 2; n.left = DOOR_CYCLES; served = cur.floor;
          end else begin
            if (!any_ahead(cur.pend, cur.floor, cur.up)) n.up = !cur.up;
            n.mode = 1;
          end
        end
      end
      1: begin
        if (fp) begin
          nf = cur.up ? cur.floor + 1 : cur.floor - 1;
          if (nf >= 0 && nf < FLOORS) begin
            n.floor = nf;
            if (cur.pend[nf]) begin
              n.mode = 2; n.left = DOOR_CYCLES; served = nf;
            end else if (!any_ahead(cur.pend, nf, cur.up)) begin
              n.mode = 0;
            end
          end
        end
      end
      default: begin
        if (c[cur.floor]) n.left = DOOR_CYCLES;
        else if (cur.left == 1) n.mode = 0;
        else n.left = cur.left - 1;
      end
    endcase
    for (int i = 0; i < FLOORS; i++) begin
      if (c[i] && !(cur.mode == 2 && i == cur.floor)) n.pend[i] = 1'b1;
      if (i == served) n.pend[i] = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_next(m, call_pulse, floor_pulse);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every registered output against the model on each falling edge.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("model motor_up",   32'(motor_up),   32'(m.mode == 1 && m.up));
      check("model motor_down", 32'(motor_down), 32'(m.mode == 1 && !m.up));
      check("model door_open",  32'(door_open),  32'(m.mode == 2));
      check("model busy",       32'(busy),       32'(m.mode != 0));
      check("model cur_floor",  32'(cur_floor),  32'(m.floor));
      check("model pending",    32'(pending),    32'(m.pend));
      check("motor exclusive",  32'(motor_up & motor_down), 32'(0));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drive inputs for one clock: set after a falling edge, hold through the rising edge.
  task automatic cycle(input logic [3:0] c, input logic fp);
    call_pulse  = c;
    floor_pulse = fp;
    @(negedge clk);
  endtask

  // Emulate the shaft: pulse the floor sensor while a motor runs, until all calls are served.
  task automatic run_to_idle(input int budget);
    bit tog;
    bit prev_door;
    bit done;
    tog = 1'b1;
    prev_door = door_open;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (!busy && pending == '0) begin
        done = 1'b1;
      end else begin
        cycle(4'b0000, (motor_up || motor_down) ? tog : 1'b0);
        tog = ~tog;
        if (door_open && !prev_door) stops.push_back(int'(cur_floor));
        prev_door = door_open;
      end
    end
    check("settle busy", 32'(busy), 32'(0));
  endtask

  task automatic count_open(output int cnt);
    cnt = door_open ? 1 : 0;
    for (int i = 0; i < 40 && door_open; i++) begin
      cycle(4'b0000, 1'b0);
      if (door_open) cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [3:0] c;
    logic fp;
    rst = 1'b1;
    call_pulse = '0;
    floor_pulse = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    check("reset busy", 32'(busy), 32'(0));
    check("reset pending", 32'(pending), 32'(0));

    // Reset while travelling up toward floor 3.
    cycle(4'b1000, 1'b0);
    cycle(4'b0000, 1'b0);
    check("A motor_up", 32'(motor_up), 32'(1));
    check("A pending", 32'(pending), 32'(4'b1000));
    #2 rst = 1'b1;
    #1;
    check("A rst motor_up", 32'(motor_up), 32'(0));
    check("A rst pending", 32'(pending), 32'(0));
    check("A rst floor", 32'(cur_floor), 32'(0));
    check("A rst busy", 32'(busy), 32'(0));
    #1 rst = 1'b0;
    @(negedge clk);

    // Call at the current floor: door after two edges, open for DOOR_CYCLES.
    cycle(4'b0001, 1'b0);
    check("B door early", 32'(door_open), 32'(0));
    cycle(4'b0000, 1'b0);
    check("B door open", 32'(door_open), 32'(1));
    check("B pending", 32'(pending), 32'(0));
    count_open(cnt);
    check("B open cycles", 32'(cnt), 32'(8));
    check("B busy after", 32'(busy), 32'(0));

    // Call at floor 2: travel up two floors and stop.
    cycle(4'b0100, 1'b0);
    check("C motor early", 32'(motor_up), 32'(0));
    cycle(4'b0000, 1'b0);
    check("C motor_up", 32'(motor_up), 32'(1));
    cycle(4'b0000, 1'b1);
    check("C floor1", 32'(cur_floor), 32'(1));
    cycle(4'b0000, 1'b1);
    check("C floor2", 32'(cur_floor), 32'(2));
    check("C motor off", 32'(motor_up), 32'(0));
    check("C door", 32'(door_open), 32'(1));
    check("C pending", 32'(pending), 32'(0));
    run_to_idle(50);

    // Door at floor 1 held by a same-floor call when two cycles remain.
    cycle(4'b0010, 1'b0);
    cycle(4'b0000, 1'b0);
    check("D motor_down", 32'(motor_down), 32'(1));
    cycle(4'b0000, 1'b1);
    check("D floor1 door", 32'(door_open), 32'(1));
    repeat (5) cycle(4'b0000, 1'b0);
    cycle(4'b0010, 1'b0);
    count_open(cnt);
    check("D reload cycles", 32'(cnt), 32'(8));
    check("D pending", 32'(pending), 32'(0));

    // Back to floor 0, then simultaneous calls latched while travelling up.
    cycle(4'b0001, 1'b0);
    run_to_idle(100);
    check("E at floor0", 32'(cur_floor), 32'(0));
    stops.delete();
    cycle(4'b1000, 1'b0);
    cycle(4'b0000, 1'b0);
    check("E motor_up", 32'(motor_up), 32'(1));
    cycle(4'b1010, 1'b0);
    check("E pending", 32'(pending), 32'(4'b1010));
    run_to_idle(200);
    check("E stop count", 32'(stops.size()), 32'(2));
    if (stops.size() == 2) begin
      check("E stop 1", 32'(stops[0]), 32'(1));
      check("E stop 2", 32'(stops[1]), 32'(3));
    end
    check("E pending end", 32'(pending), 32'(0));

    // Randomized traffic, including stray sensor pulses and one mid-run reset.
    for (int i = 0; i < 2000; i++) begin
      c  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      fp = (motor_up || motor_down) ? ($urandom_range(0, 2) == 0)
                                    : ($urandom_range(0, 9) == 0);
      if (i == 1000) begin
        call_pulse  = '0;
        floor_pulse = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("R rst pending", 32'(pending), 32'(0));
        check("R rst busy", 32'(busy), 32'(0));
        #1 rst = 1'b0;
        @(negedge clk);
      end
      cycle(c, fp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
